// File: rtl/cpu_microsequencer.sv
// Microcode address sequencer for the 6502-family cores.
// Produces the registered microcode ROM address from the current microword:
// increment, jump, conditional branch, subroutine call/return through a
// small return stack, opcode dispatch, and halt with restart.
// All state advances on the falling clock edge, qualified by enable.

module cpu_microsequencer #(
    parameter int ADDR_WIDTH     = 10,
    parameter int STACK_DEPTH    = 4,
    parameter int NUM_COND       = 8,
    parameter int DISPATCH_WIDTH = 8,
    parameter int DISPATCH_SHIFT = 2,
    parameter int RESET_ADDR     = 0
) (
    input  logic                               clock,
    input  logic                               nReset,
    input  logic                               enable,
    input  logic [2:0]                         uOp,
    input  logic [NUM_COND-1:0]                condIn,
    input  logic [$clog2(NUM_COND)-1:0]        condSel,
    input  logic                               condPolarity,
    input  logic [ADDR_WIDTH-1:0]              branchAddr,
    input  logic [DISPATCH_WIDTH-1:0]          dispatchIn,
    output logic [ADDR_WIDTH-1:0]              uAddr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stackLevel,
    output logic                               stackErr
);

    localparam int LEVEL_W = $clog2(STACK_DEPTH + 1);
    localparam int WIDE_W  = ADDR_WIDTH + DISPATCH_WIDTH + DISPATCH_SHIFT;
    localparam logic [LEVEL_W-1:0]    FULL_LEVEL = LEVEL_W'(STACK_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] RESET_VAL  = ADDR_WIDTH'(RESET_ADDR);

    typedef enum logic [2:0] {
        opNext     = 3'd0,
        opJump     = 3'd1,
        opBranch   = 3'd2,
        opCall     = 3'd3,
        opCallc    = 3'd4,
        opRet      = 3'd5,
        opDispatch = 3'd6,
        opHalt     = 3'd7
    } uOpT;

    logic [ADDR_WIDTH-1:0] uAddrReg, uAddrNext;
    logic [LEVEL_W-1:0]    levelReg, levelNext;
    logic                  errReg, errNext;

    logic                  cond;
    logic [ADDR_WIDTH-1:0] incAddr;
    logic [ADDR_WIDTH-1:0] dispatchAddr;
    logic                  pushEn;
    logic [ADDR_WIDTH-1:0] popValue;
    logic [ADDR_WIDTH-1:0] stackEntries [STACK_DEPTH];

    assign cond    = (condIn[condSel] == condPolarity);
    assign incAddr = uAddrReg + ADDR_WIDTH'(1);

    // Carry out of the dispatch sum is dropped by the truncating cast.
    assign dispatchAddr = ADDR_WIDTH'(WIDE_W'(branchAddr)
                                      + (WIDE_W'(dispatchIn) << DISPATCH_SHIFT));

    // Return stack: one register per slot, written when it is the next free slot.
    // Contents need no reset; only the level decides which entries are valid.
    genvar gi;
    generate
        for (gi = 0; gi < STACK_DEPTH; gi++) begin : gStack
            logic [ADDR_WIDTH-1:0] entryReg;

            // Capture the return address on a push into this slot.
            always_ff @(negedge clock) begin
                if (enable && pushEn && (levelReg == LEVEL_W'(gi))) begin
                    entryReg <= incAddr;
                end
            end

            assign stackEntries[gi] = entryReg;
        end
    endgenerate

    // Top-of-stack read: the entry just below the current level.
    always_comb begin
        popValue = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (levelReg == LEVEL_W'(i + 1)) begin
                popValue = stackEntries[i];
            end
        end
    end

    // Next-address, stack-level and error decision for the presented uOp.
    always_comb begin
        uAddrNext = uAddrReg;
        levelNext = levelReg;
        errNext   = errReg;
        pushEn    = 1'b0;

        unique case (uOpT'(uOp))
            opNext: begin
                uAddrNext = incAddr;
            end
            opJump: begin
                uAddrNext = branchAddr;
            end
            opBranch: begin
                uAddrNext = cond ? branchAddr : incAddr;
            end
            opCall, opCallc: begin
                if ((uOpT'(uOp) == opCall) || cond) begin
                    // The jump is taken even when the return address is lost.
                    uAddrNext = branchAddr;
                    if (levelReg == FULL_LEVEL) begin
                        errNext = 1'b1;
                    end else begin
                        pushEn    = 1'b1;
                        levelNext = levelReg + LEVEL_W'(1);
                    end
                end else begin
                    uAddrNext = incAddr;
                end
            end
            opRet: begin
                if (levelReg == '0) begin
                    uAddrNext = RESET_VAL;
                    errNext   = 1'b1;
                end else begin
                    uAddrNext = popValue;
                    levelNext = levelReg - LEVEL_W'(1);
                end
            end
            opDispatch: begin
                uAddrNext = dispatchAddr;
            end
            opHalt: begin
                // A true condition while halted restarts the microprogram;
                // the sticky error survives the restart.
                if (cond) begin
                    uAddrNext = RESET_VAL;
                    levelNext = '0;
                end
            end
            default: begin
                uAddrNext = uAddrReg;
            end
        endcase
    end

    // Sequencer state register, advanced on the falling edge when enabled.
    always_ff @(negedge clock or negedge nReset) begin
        if (!nReset) begin
            uAddrReg <= RESET_VAL;
            levelReg <= '0;
            errReg   <= 1'b0;
        end else if (enable) begin
            uAddrReg <= uAddrNext;
            levelReg <= levelNext;
            errReg   <= errNext;
        end
    end

    assign uAddr      = uAddrReg;
    assign stackLevel = levelReg;
    assign stackErr   = errReg;

endmodule

// File: tb/tb_cpu_microsequencer.sv
// Directed bench for cpu_microsequencer: a table of microword vectors with
// hand-computed results, plus hand-written reset/enable and async-reset cases.

module tb_cpu_microsequencer;

    logic       clock = 1'b1;
    logic       nReset = 1'b0;
    logic       enable = 1'b1;
    logic [2:0] uOp = 3'd1;
    logic [7:0] condIn = 8'h00;
    logic [2:0] condSel = 3'd0;
    logic       condPolarity = 1'b0;
    logic [9:0] branchAddr = 10'h155;
    logic [7:0] dispatchIn = 8'h00;
    logic [9:0] uAddr;
    logic [2:0] stackLevel;
    logic       stackErr;

    int checks = 0;
    int failures = 0;

    cpu_microsequencer dut (
        .clock        (clock),
        .nReset       (nReset),
        .enable       (enable),
        .uOp          (uOp),
        .condIn       (condIn),
        .condSel      (condSel),
        .condPolarity (condPolarity),
        .branchAddr   (branchAddr),
        .dispatchIn   (dispatchIn),
        .uAddr        (uAddr),
        .stackLevel   (stackLevel),
        .stackErr     (stackErr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] op;
        logic [7:0] cIn;
        logic [2:0] cSel;
        logic       cPol;
        logic [9:0] br;
        logic [7:0] disp;
        logic [9:0] expAddr;
        logic [2:0] expLevel;
        logic       expErr;
    } vecT;

    vecT vecs[$];

    task automatic addVec(input logic [2:0] op, input logic [7:0] cIn, input logic [2:0] cSel,
                          input logic cPol, input logic [9:0] br, input logic [7:0] disp,
                          input logic [9:0] expAddr, input logic [2:0] expLevel, input logic expErr);
        vecT v;
        v.op = op; v.cIn = cIn; v.cSel = cSel; v.cPol = cPol; v.br = br; v.disp = disp;
        v.expAddr = expAddr; v.expLevel = expLevel; v.expErr = expErr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic chkAll(input string name, input int idx, input logic [9:0] a,
                          input logic [2:0] l, input logic e);
        chk({name, ".uAddr"}, idx, 32'(uAddr), 32'(a));
        chk({name, ".stackLevel"}, idx, 32'(stackLevel), 32'(l));
        chk({name, ".stackErr"}, idx, 32'(stackErr), 32'(e));
        $display("step %s[%0d]: uOp=%0d uAddr=0x%03h level=%0d err=%0b",
                 name, idx, uOp, uAddr, stackLevel, stackErr);
    endtask

    task automatic edgeStep();
        @(negedge clock);
        #1;
    endtask

    initial begin
        // Ops: 0 NEXT 1 JUMP 2 BRANCH 3 CALL 4 CALLC 5 RET 6 DISPATCH 7 HALT
        // Branch polarity and increment wrap.
        addVec(3'd1, 8'h00, 3'd0, 1'b0, 10'h010, 8'h00, 10'h010, 3'd0, 1'b0);
        addVec(3'd2, 8'h04, 3'd2, 1'b1, 10'h200, 8'h00, 10'h200, 3'd0, 1'b0);
        addVec(3'd1, 8'h00, 3'd0, 1'b0, 10'h010, 8'h00, 10'h010, 3'd0, 1'b0);
        addVec(3'd2, 8'h04, 3'd2, 1'b0, 10'h200, 8'h00, 10'h011, 3'd0, 1'b0);
        addVec(3'd1, 8'h00, 3'd0, 1'b0, 10'h3FF, 8'h00, 10'h3FF, 3'd0, 1'b0);
        addVec(3'd0, 8'h00, 3'd0, 1'b0, 10'h000, 8'h00, 10'h000, 3'd0, 1'b0);
        // Nested calls.
        addVec(3'd1, 8'h00, 3'd0, 1'b0, 10'h020, 8'h00, 10'h020, 3'd0, 1'b0);
        addVec(3'd3, 8'h00, 3'd0, 1'b0, 10'h100, 8'h00, 10'h100, 3'd1, 1'b0);
        addVec(3'd3, 8'h00, 3'd0, 1'b0, 10'h180, 8'h00, 10'h180, 3'd2, 1'b0);
        addVec(3'd5, 8'h00, 3'd0, 1'b0, 10'h000, 8'h00, 10'h101, 3'd1, 1'b0);
        addVec(3'd5, 8'h00, 3'd0, 1'b0, 10'h000, 8'h00, 10'h021, 3'd0, 1'b0);
        // Conditional call: not taken, then taken, then return.
        addVec(3'd4, 8'h00, 3'd2, 1'b1, 10'h300, 8'h00, 10'h022, 3'd0, 1'b0);
        addVec(3'd4, 8'h04, 3'd2, 1'b1, 10'h300, 8'h00, 10'h300, 3'd1, 1'b0);
        addVec(3'd5, 8'h00, 3'd0, 1'b0, 10'h000, 8'h00, 10'h023, 3'd0, 1'b0);
        // Overflow: five calls into a four-deep stack.
        addVec(3'd3, 8'h00, 3'd0, 1'b0, 10'h040, 8'h00, 10'h040, 3'd1, 1'b0);
        addVec(3'd3, 8'h00, 3'd0, 1'b0, 10'h050, 8'h00, 10'h050, 3'd2, 1'b0);
        addVec(3'd3, 8'h00, 3'd0, 1'b0, 10'h060, 8'h00, 10'h060, 3'd3, 1'b0);
        addVec(3'd3, 8'h00, 3'd0, 1'b0, 10'h070, 8'h00, 10'h070, 3'd4, 1'b0);
        addVec(3'd3, 8'h00, 3'd0, 1'b0, 10'h080, 8'h00, 10'h080, 3'd4, 1'b1);
        // Underflow: four good returns, the fifth lands on the reset address.
        addVec(3'd5, 8'h00, 3'd0, 1'b0, 10'h000, 8'h00, 10'h061, 3'd3, 1'b1);
        addVec(3'd5, 8'h00, 3'd0, 1'b0, 10'h000, 8'h00, 10'h051, 3'd2, 1'b1);
        addVec(3'd5, 8'h00, 3'd0, 1'b0, 10'h000, 8'h00, 10'h041, 3'd1, 1'b1);
        addVec(3'd5, 8'h00, 3'd0, 1'b0, 10'h000, 8'h00, 10'h024, 3'd0, 1'b1);
        addVec(3'd5, 8'h00, 3'd0, 1'b0, 10'h000, 8'h00, 10'h000, 3'd0, 1'b1);
        // Dispatch, including carry-out discard.
        addVec(3'd6, 8'h00, 3'd0, 1'b0, 10'h100, 8'hA9, 10'h3A4, 3'd0, 1'b1);
        addVec(3'd6, 8'h00, 3'd0, 1'b0, 10'h200, 8'hFF, 10'h1FC, 3'd0, 1'b1);
        // Halt with condition false holds, then restart.
        addVec(3'd3, 8'h00, 3'd0, 1'b0, 10'h0F0, 8'h00, 10'h0F0, 3'd1, 1'b1);
        for (int i = 0; i < 4; i++)
            addVec(3'd7, 8'h00, 3'd5, 1'b1, 10'h3FF, 8'h00, 10'h0F0, 3'd1, 1'b1);
        addVec(3'd7, 8'h20, 3'd5, 1'b1, 10'h3FF, 8'h00, 10'h000, 3'd0, 1'b1);

        // Reset held: JUMP presented but ignored.
        edgeStep();
        chkAll("reset", 0, 10'h000, 3'd0, 1'b0);
        edgeStep();
        chkAll("reset", 1, 10'h000, 3'd0, 1'b0);

        // Release reset with enable low: state holds.
        nReset = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edgeStep();
            chkAll("disabled", i, 10'h000, 3'd0, 1'b0);
        end
        enable = 1'b1;
        edgeStep();
        chkAll("enabled", 0, 10'h155, 3'd0, 1'b0);

        foreach (vecs[i]) begin
            uOp = vecs[i].op;
            condIn = vecs[i].cIn;
            condSel = vecs[i].cSel;
            condPolarity = vecs[i].cPol;
            branchAddr = vecs[i].br;
            dispatchIn = vecs[i].disp;
            edgeStep();
            chkAll("vec", i, vecs[i].expAddr, vecs[i].expLevel, vecs[i].expErr);
        end

        // Async reset in the middle of a call chain.
        condIn = 8'h00;
        uOp = 3'd3;
        branchAddr = 10'h100;
        edgeStep();
        chkAll("chain", 0, 10'h100, 3'd1, 1'b1);
        branchAddr = 10'h180;
        edgeStep();
        chkAll("chain", 1, 10'h180, 3'd2, 1'b1);
        #3;
        nReset = 1'b0;
        #1;
        chkAll("asyncReset", 0, 10'h000, 3'd0, 1'b0);
        uOp = 3'd0;
        edgeStep();
        chkAll("asyncReset", 1, 10'h000, 3'd0, 1'b0);
        nReset = 1'b1;
        edgeStep();
        chkAll("afterReset", 0, 10'h001, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
